// File: rtl/route_length_engine.sv
// Streaming tour-length engine: accepts city points, computes floor-Euclidean
// segment lengths with a bit-serial restoring square root and accumulates them.
module route_length_engine #(
    parameter int SIZE        = 8,
    parameter int NumOfCities = 32,
    parameter int IDX_W       = $clog2(NumOfCities) + 1,
    parameter int ACC_W       = SIZE + 1 + $clog2(NumOfCities)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_x,
    input  logic [SIZE-1:0]  in_y,
    input  logic             in_last,
    input  logic             close_loop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] tour_len,
    output logic [IDX_W-1:0] num_pts,
    output logic             too_many
);

    localparam int R     = SIZE + 1;
    localparam int DW    = 2 * SIZE + 1;
    localparam int CNT_W = $clog2(R + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE);
    localparam logic [IDX_W-1:0] PTS_MAX  = IDX_W'(NumOfCities);
    localparam logic [IDX_W-1:0] PTS_SAT  = IDX_W'(NumOfCities + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SQRT, CLOSE, DONE} state_t;

    state_t            state, state_nxt;
    logic [SIZE-1:0]   first_x, first_y, prev_x, prev_y;
    logic              close_en, last_seg;
    logic [2*R-1:0]    d;
    logic [R-1:0]      rem;
    logic [R-1:0]      root;
    logic [CNT_W-1:0]  cnt;

    logic              in_hs, out_hs, root_last;
    logic [R+1:0]      rem_sh, trial;
    logic              ge;
    logic [R-1:0]      root_nxt;

    function automatic logic [DW-1:0] sq_dist(input logic [SIZE-1:0] ax, input logic [SIZE-1:0] ay,
                                              input logic [SIZE-1:0] bx, input logic [SIZE-1:0] by);
        logic [SIZE-1:0] dx, dy;
        dx = (ax >= bx) ? ax - bx : bx - ax;
        dy = (ay >= by) ? ay - by : by - ay;
        return DW'(dx) * DW'(dx) + DW'(dy) * DW'(dy);
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [R-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W + 1)'(b);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign root_last = (cnt == CNT_LAST);

    // One restoring-root step: bring down two radicand bits, try 4*root+1.
    always_comb begin
        rem_sh   = {rem, d[2*R-1 -: 2]};
        trial    = {root, 2'b01};
        ge       = (rem_sh >= trial);
        root_nxt = {root[R-2:0], ge};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_hs) state_nxt = in_last ? CLOSE : LOAD;
            LOAD:  if (in_hs) state_nxt = SQRT;
            SQRT:  if (root_last) state_nxt = !last_seg ? LOAD : (close_en ? CLOSE : DONE);
            CLOSE: if (root_last) state_nxt = DONE;
            DONE:  if (out_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE) || (state_nxt == LOAD);
            out_valid <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_x  <= '0;
            first_y  <= '0;
            prev_x   <= '0;
            prev_y   <= '0;
            close_en <= 1'b0;
            last_seg <= 1'b0;
            d        <= '0;
            rem      <= '0;
            root     <= '0;
            cnt      <= '0;
            tour_len <= '0;
            num_pts  <= '0;
            too_many <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_hs) begin
                    first_x  <= in_x;
                    first_y  <= in_y;
                    prev_x   <= in_x;
                    prev_y   <= in_y;
                    close_en <= close_loop;
                    last_seg <= in_last;
                    tour_len <= '0;
                    num_pts  <= IDX_W'(1);
                    too_many <= 1'b0;
                    d        <= '0;
                    rem      <= '0;
                    root     <= '0;
                    // A single-point tour runs one zero-length root step so the
                    // result follows the same registered path as longer tours.
                    cnt      <= in_last ? CNT_LAST : '0;
                end
                LOAD: if (in_hs) begin
                    d        <= {1'b0, sq_dist(in_x, in_y, prev_x, prev_y)};
                    rem      <= '0;
                    root     <= '0;
                    cnt      <= '0;
                    prev_x   <= in_x;
                    prev_y   <= in_y;
                    last_seg <= in_last;
                    if (num_pts == PTS_MAX) too_many <= 1'b1;
                    if (num_pts != PTS_SAT) num_pts <= num_pts + 1'b1;
                end
                SQRT, CLOSE: begin
                    d    <= {d[2*R-3:0], 2'b00};
                    rem  <= ge ? R'(rem_sh - trial) : R'(rem_sh);
                    root <= root_nxt;
                    cnt  <= cnt + 1'b1;
                    if (root_last) begin
                        tour_len <= sat_add(tour_len, root_nxt);
                        // Closing segment is loaded straight away so its root
                        // starts on the very next edge.
                        if (state == SQRT && last_seg && close_en) begin
                            d    <= {1'b0, sq_dist(prev_x, prev_y, first_x, first_y)};
                            rem  <= '0;
                            root <= '0;
                            cnt  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
